// File: rtl/seq_detect_pkg.sv
// Shared types and one-hot encodings for the pattern sequencer and its detector.
package seq_detect_pkg;

    localparam int DET_W = 9;

    localparam logic [DET_W-1:0] ST_A = 9'h001;
    localparam logic [DET_W-1:0] ST_B = 9'h002;
    localparam logic [DET_W-1:0] ST_C = 9'h004;
    localparam logic [DET_W-1:0] ST_D = 9'h008;
    localparam logic [DET_W-1:0] ST_E = 9'h010;
    localparam logic [DET_W-1:0] ST_F = 9'h020;
    localparam logic [DET_W-1:0] ST_G = 9'h040;
    localparam logic [DET_W-1:0] ST_H = 9'h080;
    localparam logic [DET_W-1:0] ST_I = 9'h100;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Control/status bundle between the board-side driver (master) and the sequencer (slave).
interface seq_detect_ctrl_if
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = 16,
    parameter int CNT_W = 5
);
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             w;
    logic             z;
    logic [DET_W-1:0] state;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hits;

    modport master (
        output start, pattern, len,
        input  w, z, state, busy, done, hits
    );

    modport slave (
        input  start, pattern, len,
        output w, z, state, busy, done, hits
    );

endinterface

// File: rtl/seq_detect_fsm.sv
// One-hot "four-in-a-row" detector; advances only when en is high, z flags states E and I.
//  state | meaning
//  A     | start, nothing seen
//  B,C,D | one/two/three zeros seen
//  E     | four or more zeros (z=1)
//  F,G,H | one/two/three ones seen
//  I     | four or more ones (z=1)
module seq_detect_fsm
    import seq_detect_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             w,
    output logic [DET_W-1:0] state,
    output logic             z
);

    logic [DET_W-1:0] state_q, state_d, adv;

    always_comb begin
        adv     = '0;
        adv[1]  = ~w & (state_q[0] | state_q[5] | state_q[6] | state_q[7] | state_q[8]);
        adv[2]  = ~w & state_q[1];
        adv[3]  = ~w & state_q[2];
        adv[4]  = ~w & (state_q[3] | state_q[4]);
        adv[5]  =  w & (|state_q[4:0]);
        adv[6]  =  w & state_q[5];
        adv[7]  =  w & state_q[6];
        adv[8]  =  w & (state_q[7] | state_q[8]);

        state_d = state_q;
        if (clr) begin
            state_d = ST_A;
        end else if (en) begin
            state_d = adv;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_A;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;
    assign z     = state_q[4] | state_q[8];

endmodule

// File: rtl/seq_detect_ctrl.sv
// Plays a latched pattern LSB-first into the detector and counts z hits.
// Define SEQ_RATE_DIV_EN to step once every DIV clocks instead of every clock.
//  state | meaning
//  IDLE  | waiting for start, w=0
//  CLEAR | detector cleared, index and hit count zeroed
//  RUN   | one pattern bit per step
//  DRAIN | last hit sample after final step
//  DONE  | done pulse, back to IDLE
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = 16,
    parameter int CNT_W = 5,
    parameter int DIV   = 50_000_000
) (
    input  logic               clk,
    input  logic               reset,
    seq_detect_ctrl_if.slave   bus
);

    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    ctrl_state_t      ctrl_q, ctrl_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] hits_q, hits_d;
    logic             step_dly_q;
    logic             tick;
    logic             step;
    logic             det_clr;
    logic             w_c;
    logic [DET_W-1:0] det_state;
    logic             det_z;

`ifdef SEQ_RATE_DIV_EN
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;

    assign tick = (presc_q == PW'(DIV - 1));

    // Held at zero outside RUN so every run starts a fresh full period.
    always_comb begin
        presc_d = '0;
        if (ctrl_q == RUN && !tick) begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign step = (ctrl_q == RUN) && tick;

    always_comb begin
        ctrl_d  = ctrl_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        hits_d  = hits_q;
        det_clr = 1'b0;
        w_c     = 1'b0;

        if (step_dly_q && det_z && (hits_q != {CNT_W{1'b1}})) begin
            hits_d = hits_q + CNT_W'(1);
        end

        unique case (ctrl_q)
            IDLE: begin
                if (bus.start) begin
                    pat_d  = bus.pattern;
                    len_d  = (bus.len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.len;
                    ctrl_d = CLEAR;
                end
            end
            CLEAR: begin
                det_clr = 1'b1;
                idx_d   = '0;
                hits_d  = '0;
                ctrl_d  = (len_q == '0) ? DRAIN : RUN;
            end
            RUN: begin
                w_c = pat_q[idx_q[IDX_W-1:0]];
                if (step) begin
                    idx_d = idx_q + LEN_W'(1);
                    if (idx_q == len_q - LEN_W'(1)) begin
                        ctrl_d = DRAIN;
                    end
                end
            end
            DRAIN: ctrl_d = DONE;
            DONE:  ctrl_d = IDLE;
            default: ctrl_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= IDLE;
            pat_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            hits_q     <= '0;
            step_dly_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            pat_q      <= pat_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            hits_q     <= hits_d;
            step_dly_q <= step;
        end
    end

    seq_detect_fsm u_fsm (
        .clk   (clk),
        .reset (reset),
        .clr   (det_clr),
        .en    (step),
        .w     (w_c),
        .state (det_state),
        .z     (det_z)
    );

    assign bus.w     = w_c;
    assign bus.z     = det_z;
    assign bus.state = det_state;
    assign bus.busy  = (ctrl_q != IDLE);
    assign bus.done  = (ctrl_q == DONE);
    assign bus.hits  = hits_q;

endmodule
